ysyx_23060236_rd_xbar: RTL and testbench
========================================

// Module: ysyx_23060236_rd_xbar
// PURPOSE
//  Single-master AXI-lite read crossbar in front of the CLINT and the memory port.
//  Accepts one LSU read, decodes the address and forwards AR to the CLINT or the memory slave.
//  Returns the chosen slave's R beat to the LSU.
//  Addresses hitting neither window get an internal DECERR response.
//  One transaction outstanding at a time; no reordering.
// PARAMETERS
//  CLINT_BASE  32'h0200_0000  CLINT window base
//  CLINT_MASK  32'hFFFF_0000  hit when (addr & MASK) == BASE
//  MEM_BASE    32'h8000_0000  memory window base
//  MEM_MASK    32'hF800_0000  hit when (addr & MASK) == BASE
// PORTS
//  clock       in   1   sole clock, rising edge
//  reset       in   1   asynchronous, active-low (0 = reset)
//  araddr      in   32  master read address
//  arvalid     in   1   master AR valid
//  arready     out  1   master AR ready
//  rdata       out  32  master read data
//  rresp       out  2   master read response
//  rvalid      out  1   master R valid
//  rready      in   1   master R ready
//  clint_araddr/clint_arvalid out 32/1; clint_arready in 1
//  clint_rdata in 32; clint_rresp in 2; clint_rvalid in 1; clint_rready out 1
//  mem_araddr/mem_arvalid out 32/1; mem_arready in 1
//  mem_rdata in 32; mem_rresp in 2; mem_rvalid in 1; mem_rready out 1
// BEHAVIOUR
//  FSM states: IDLE, AR, R, ERR. Registers: state, addr_q[31:0], sel_q (CLINT/MEM).
//  reset low (async): state=IDLE, addr_q=0, sel_q=MEM.
//   Outputs then: arready=1, rvalid=0, clint/mem_arvalid=0, clint/mem_rready=0, rdata=0, rresp=0.
//  IDLE: arready=1. On arvalid: latch addr_q=araddr.
//   CLINT hit -> sel_q=CLINT, goto AR. MEM hit -> sel_q=MEM, goto AR. Neither -> goto ERR.
//   CLINT decode has priority if both windows match.
//  AR: arready=0. <sel>_arvalid=1 and <sel>_araddr=addr_q; the other slave's arvalid=0.
//   <sel>_arready=1 -> goto R. arvalid is held stable until that handshake.
//  R: rvalid=<sel>_rvalid, rdata=<sel>_rdata, rresp=<sel>_rresp (combinational pass-through).
//   <sel>_rready=rready; the other slave's rready=0.
//   rvalid&rready -> goto IDLE.
//  ERR: rvalid=1, rdata=0, rresp=2'b11 (DECERR). rready -> IDLE. No slave is touched.
//  Latency with zero-wait slaves (arvalid..rvalid):
//   CLINT: AR accepted cycle 0, slave AR cycle 1, rvalid cycle 2.
//   ERR: rvalid at cycle 1.
//  Master back-pressure: R state holds indefinitely while rready=0, and rdata stays as driven by the slave.
//  Back-to-back: arready returns 1 the cycle after the R handshake. No AR is accepted during AR/R/ERR.
//  Outside IDLE: arready=0. Outside R/ERR: rvalid=0, rdata=0, rresp=0.
//  *_araddr outputs always drive addr_q; they are gated only by arvalid.
//  Reset mid-transaction: FSM returns to IDLE immediately and the in-flight read is dropped.
//   Slaves share this reset.
//  Unused slave response inputs are ignored.
// STRUCTURE
//  Shared defines header: state encodings, RRESP codes (OKAY=2'b00, DECERR=2'b11), default window constants.
//  One natural sub-module: ysyx_23060236_rd_xbar_dec.
//   Combinational address -> {hit_clint, hit_mem} with mask/base parameters.
//  FSM and address/select registers are inline with async active-low reset.
// TESTING
//  1 CLINT read: araddr=32'h0200_BFF8, slave returns 32'h1234_5678 OKAY.
//    -> rdata=32'h1234_5678, rresp=0, only clint_arvalid/clint_rready pulse, rvalid at cycle 2.
//  2 MEM read with mem_arready held 0 for 3 cycles.
//    -> mem_arvalid stays 1 with mem_araddr=32'h8000_0010; R follows after the handshake; clint_* remain 0.
//  3 Unmapped araddr=32'h1000_0000 -> rvalid=1 at cycle 1, rresp=2'b11, rdata=0, no slave arvalid.
//  4 Master rready=0 for 5 cycles in R -> rvalid/rdata stable; arready=0; second arvalid not accepted until after R handshake.
//  5 Back-to-back CLINT 0x0200_BFF8 then 0x0200_BFFC -> two ordered responses (low then high word), arready=1 between them.
//  6 reset driven low while in AR state -> next cycle state IDLE, arready=1, all slave valids/readies 0.

Source files
------------

// File: rtl/ysyx_23060236_rd_xbar_pkg.sv
// Shared types and constants for the single-master AXI-lite read crossbar:
// FSM states, slave select, RRESP codes and the default address windows.
package ysyx_23060236_rd_xbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic {
    SEL_MEM   = 1'b0,
    SEL_CLINT = 1'b1
  } sel_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_MASK   = 32'hF800_0000;

  // A window matches when the masked address equals its base.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_23060236_rd_xbar_dec.sv
// Combinational address decoder: reports which slave windows an address falls in.
// Both hits may be set at once; the crossbar resolves priority.
module ysyx_23060236_rd_xbar_dec
  import ysyx_23060236_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
  input  logic [31:0] addr,
  output logic        hit_clint,
  output logic        hit_mem
);

  assign hit_clint = win_hit(addr, CLINT_BASE, CLINT_MASK);
  assign hit_mem   = win_hit(addr, MEM_BASE, MEM_MASK);

endmodule

// File: rtl/ysyx_23060236_rd_xbar.sv
// Single-master AXI-lite read crossbar routing one outstanding LSU read to the
// CLINT or the memory port, answering unmapped addresses with DECERR.
module ysyx_23060236_rd_xbar
  import ysyx_23060236_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_MASK   = DEF_MEM_MASK
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] clint_araddr,
  output logic        clint_arvalid,
  input  logic        clint_arready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr_q;
  sel_t        sel_q;
  logic        hit_clint;
  logic        hit_mem;
  logic        sel_clint;
  logic        sel_arready;
  logic        sel_rvalid;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_rresp;

  ysyx_23060236_rd_xbar_dec #(
    .CLINT_BASE(CLINT_BASE),
    .CLINT_MASK(CLINT_MASK),
    .MEM_BASE  (MEM_BASE),
    .MEM_MASK  (MEM_MASK)
  ) u_dec (
    .addr     (araddr),
    .hit_clint(hit_clint),
    .hit_mem  (hit_mem)
  );

  // The address is captured even for unmapped reads; sel_q keeps its old value then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      sel_q  <= SEL_MEM;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && arvalid) begin
        addr_q <= araddr;
        if (hit_clint) begin
          sel_q <= SEL_CLINT;
        end else if (hit_mem) begin
          sel_q <= SEL_MEM;
        end
      end
    end
  end

  assign sel_clint = (sel_q == SEL_CLINT);

  always_comb begin
    sel_arready = mem_arready;
    sel_rvalid  = mem_rvalid;
    sel_rdata   = mem_rdata;
    sel_rresp   = mem_rresp;
    if (sel_clint) begin
      sel_arready = clint_arready;
      sel_rvalid  = clint_rvalid;
      sel_rdata   = clint_rdata;
      sel_rresp   = clint_rresp;
    end
  end

  assign clint_araddr = addr_q;
  assign mem_araddr   = addr_q;

  // CLINT wins when both windows match.
  always_comb begin
    state_nx      = state;
    arready       = 1'b0;
    rvalid        = 1'b0;
    rdata         = '0;
    rresp         = RESP_OKAY;
    clint_arvalid = 1'b0;
    mem_arvalid   = 1'b0;
    clint_rready  = 1'b0;
    mem_rready    = 1'b0;
    case (state)
      ST_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          state_nx = (hit_clint || hit_mem) ? ST_AR : ST_ERR;
        end
      end
      ST_AR: begin
        clint_arvalid = sel_clint;
        mem_arvalid   = !sel_clint;
        if (sel_arready) begin
          state_nx = ST_R;
        end
      end
      ST_R: begin
        rvalid       = sel_rvalid;
        rdata        = sel_rdata;
        rresp        = sel_rresp;
        clint_rready = sel_clint && rready;
        mem_rready   = !sel_clint && rready;
        if (sel_rvalid && rready) begin
          state_nx = ST_IDLE;
        end
      end
      ST_ERR: begin
        rvalid = 1'b1;
        rresp  = RESP_DECERR;
        if (rready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060236_rd_xbar.sv
// Self-checking bench for the read crossbar: reactive slave models, a
// transaction-level reference model compared every cycle, and directed scenarios.
module tb_ysyx_23060236_rd_xbar;

  localparam int T_ERR   = 0;
  localparam int T_CLINT = 1;
  localparam int T_MEM   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] clint_araddr;
  logic        clint_arvalid;
  logic        clint_arready = 1'b0;
  logic [31:0] clint_rdata = '0;
  logic [1:0]  clint_rresp = '0;
  logic        clint_rvalid = 1'b0;
  logic        clint_rready;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;

  ysyx_23060236_rd_xbar dut (
    .clock        (clock),
    .reset        (reset),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .clint_araddr (clint_araddr),
    .clint_arvalid(clint_arvalid),
    .clint_arready(clint_arready),
    .clint_rdata  (clint_rdata),
    .clint_rresp  (clint_rresp),
    .clint_rvalid (clint_rvalid),
    .clint_rready (clint_rready),
    .mem_araddr   (mem_araddr),
    .mem_arvalid  (mem_arvalid),
    .mem_arready  (mem_arready),
    .mem_rdata    (mem_rdata),
    .mem_rresp    (mem_rresp),
    .mem_rvalid   (mem_rvalid),
    .mem_rready   (mem_rready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Slave contents: two fixed CLINT words (mtime low/high), everything else a simple hash.
  function automatic logic [31:0] clint_word(input logic [31:0] a);
    if (a == 32'h0200_BFF8) return 32'h1234_5678;
    if (a == 32'h0200_BFFC) return 32'h0000_00AB;
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic int target(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0200_0000) return T_CLINT;
    if ((a & 32'hF800_0000) == 32'h8000_0000) return T_MEM;
    return T_ERR;
  endfunction

  // Handshakes are observed mid-cycle, when every signal is settled for the coming edge.
  logic        c_snap_arv = 1'b0, c_snap_arhs = 1'b0, c_snap_rhs = 1'b0;
  logic        m_snap_arv = 1'b0, m_snap_arhs = 1'b0, m_snap_rhs = 1'b0;
  logic [31:0] c_snap_addr = '0, m_snap_addr = '0;
  always @(negedge clock) begin
    c_snap_arv  = clint_arvalid;
    c_snap_arhs = clint_arvalid && clint_arready;
    c_snap_rhs  = clint_rvalid && clint_rready;
    c_snap_addr = clint_araddr;
    m_snap_arv  = mem_arvalid;
    m_snap_arhs = mem_arvalid && mem_arready;
    m_snap_rhs  = mem_rvalid && mem_rready;
    m_snap_addr = mem_araddr;
  end

  int          clint_ar_wait = 0;
  int          mem_ar_wait = 0;
  logic        c_busy = 1'b0, m_busy_s = 1'b0;
  int          c_arcnt = 0, m_arcnt = 0;
  logic [31:0] c_addr = '0, m_addr_s = '0;

  always begin : clint_slave
    @(posedge clock);
    #1;
    if (!reset) begin
      c_busy  = 1'b0;
      c_arcnt = 0;
    end else begin
      if (c_snap_rhs) c_busy = 1'b0;
      if (c_snap_arhs) begin
        c_busy  = 1'b1;
        c_addr  = c_snap_addr;
        c_arcnt = 0;
      end else if (c_snap_arv) begin
        c_arcnt++;
      end
    end
    clint_arready = !c_busy && (c_arcnt >= clint_ar_wait);
    clint_rvalid  = c_busy;
    clint_rdata   = c_busy ? clint_word(c_addr) : 32'hBAD0_C1A7;
    clint_rresp   = c_busy ? 2'b00 : 2'b10;
  end

  always begin : mem_slave
    @(posedge clock);
    #1;
    if (!reset) begin
      m_busy_s = 1'b0;
      m_arcnt  = 0;
    end else begin
      if (m_snap_rhs) m_busy_s = 1'b0;
      if (m_snap_arhs) begin
        m_busy_s = 1'b1;
        m_addr_s = m_snap_addr;
        m_arcnt  = 0;
      end else if (m_snap_arv) begin
        m_arcnt++;
      end
    end
    mem_arready = !m_busy_s && (m_arcnt >= mem_ar_wait);
    mem_rvalid  = m_busy_s;
    mem_rdata   = m_busy_s ? mem_word(m_addr_s) : 32'hBAD0_3E30;
    mem_rresp   = m_busy_s ? 2'b00 : 2'b10;
  end

  // Transaction model: at most one read in flight, forwarded to its decoded slave.
  logic        m_busy = 1'b0;
  logic        m_ar_done = 1'b0;
  int          m_tgt = T_ERR;
  logic [31:0] m_addr = '0;

  always @(negedge clock) begin : check_output
    logic to_c, to_m, exp_rv;
    if (!reset) begin
      check_bit("rst_arready", arready, 1'b1);
      check_bit("rst_rvalid", rvalid, 1'b0);
      check_bit("rst_clint_arvalid", clint_arvalid, 1'b0);
      check_bit("rst_mem_arvalid", mem_arvalid, 1'b0);
      check_bit("rst_clint_rready", clint_rready, 1'b0);
      check_bit("rst_mem_rready", mem_rready, 1'b0);
      check_word("rst_rdata", rdata, 32'h0);
      check_word("rst_rresp", 32'(rresp), 32'h0);
      m_busy = 1'b0;
    end else begin
      to_c = m_busy && (m_tgt == T_CLINT);
      to_m = m_busy && (m_tgt == T_MEM);
      if (!m_busy) exp_rv = 1'b0;
      else if (m_tgt == T_ERR) exp_rv = 1'b1;
      else if (!m_ar_done) exp_rv = 1'b0;
      else exp_rv = to_c ? clint_rvalid : mem_rvalid;

      check_bit("arready", arready, !m_busy);
      check_bit("clint_arvalid", clint_arvalid, to_c && !m_ar_done);
      check_bit("mem_arvalid", mem_arvalid, to_m && !m_ar_done);
      if (to_c && !m_ar_done) check_word("clint_araddr", clint_araddr, m_addr);
      if (to_m && !m_ar_done) check_word("mem_araddr", mem_araddr, m_addr);
      check_bit("clint_rready", clint_rready, to_c && m_ar_done && rready);
      check_bit("mem_rready", mem_rready, to_m && m_ar_done && rready);
      check_bit("rvalid", rvalid, exp_rv);

      if (m_busy && m_tgt == T_ERR) begin
        check_word("err_rdata", rdata, 32'h0);
        check_word("err_rresp", 32'(rresp), 32'h3);
      end else if (!m_busy || !m_ar_done) begin
        check_word("idle_rdata", rdata, 32'h0);
        check_word("idle_rresp", 32'(rresp), 32'h0);
      end else if (exp_rv && rready) begin
        check_word("resp_rdata", rdata, to_c ? clint_word(m_addr) : mem_word(m_addr));
        check_word("resp_rresp", 32'(rresp), 32'h0);
      end

      if (rvalid && rready) n_resp++;

      if (m_busy) begin
        if (exp_rv && rready) begin
          m_busy = 1'b0;
        end else if (!m_ar_done && ((to_c && clint_arready) || (to_m && mem_arready))) begin
          m_ar_done = 1'b1;
        end
      end else if (arvalid) begin
        m_busy    = 1'b1;
        m_addr    = araddr;
        m_tgt     = target(araddr);
        m_ar_done = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic av, input logic [31:0] a, input logic rr);
    @(posedge clock);
    #1;
    arvalid = av;
    araddr  = a;
    rready  = rr;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    @(negedge clock);
    check_bit("t0_reset_arready", arready, 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;

    // CLINT read with a zero-wait slave: rvalid two cycles after acceptance.
    apply_stimulus(1'b1, 32'h0200_BFF8, 1'b1);
    @(negedge clock);
    check_bit("t1_c0_arready", arready, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check_bit("t1_c1_clint_arvalid", clint_arvalid, 1'b1);
    check_word("t1_c1_clint_araddr", clint_araddr, 32'h0200_BFF8);
    check_bit("t1_c1_rvalid", rvalid, 1'b0);
    @(negedge clock);
    check_bit("t1_c2_rvalid", rvalid, 1'b1);
    check_word("t1_c2_rdata", rdata, 32'h1234_5678);
    check_word("t1_c2_rresp", 32'(rresp), 32'h0);
    check_bit("t1_c2_mem_rready", mem_rready, 1'b0);
    @(negedge clock);
    check_bit("t1_c3_arready", arready, 1'b1);
    check_bit("t1_c3_rvalid", rvalid, 1'b0);

    // Memory read with the slave stalling AR for three cycles.
    mem_ar_wait = 3;
    apply_stimulus(1'b1, 32'h8000_0010, 1'b1);
    @(negedge clock);
    check_bit("t2_c0_arready", arready, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      check_bit($sformatf("t2_c%0d_mem_arvalid", c), mem_arvalid, 1'b1);
      check_word($sformatf("t2_c%0d_mem_araddr", c), mem_araddr, 32'h8000_0010);
      check_bit($sformatf("t2_c%0d_clint_arvalid", c), clint_arvalid, 1'b0);
      check_bit($sformatf("t2_c%0d_rvalid", c), rvalid, 1'b0);
    end
    @(negedge clock);
    check_bit("t2_c5_rvalid", rvalid, 1'b1);
    check_word("t2_c5_rdata", rdata, 32'hDA5A_5A4A);
    check_bit("t2_c5_clint_rready", clint_rready, 1'b0);
    mem_ar_wait = 0;
    @(negedge clock);

    // Unmapped address answered internally with DECERR one cycle later.
    apply_stimulus(1'b1, 32'h1000_0000, 1'b1);
    @(negedge clock);
    check_bit("t3_c0_arready", arready, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check_bit("t3_c1_rvalid", rvalid, 1'b1);
    check_word("t3_c1_rresp", 32'(rresp), 32'h3);
    check_word("t3_c1_rdata", rdata, 32'h0);
    check_bit("t3_c1_clint_arvalid", clint_arvalid, 1'b0);
    check_bit("t3_c1_mem_arvalid", mem_arvalid, 1'b0);
    @(negedge clock);
    check_bit("t3_c2_rvalid", rvalid, 1'b0);
    check_bit("t3_c2_arready", arready, 1'b1);

    // Master back-pressure for five cycles while a second request waits.
    apply_stimulus(1'b1, 32'h8000_0100, 1'b0);
    @(negedge clock);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check_bit("t4_c2_rvalid", rvalid, 1'b1);
    check_word("t4_c2_rdata", rdata, 32'hDA5A_5B5A);
    check_bit("t4_c2_mem_rready", mem_rready, 1'b0);
    apply_stimulus(1'b1, 32'h8000_0200, 1'b0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clock);
      check_bit($sformatf("t4_c%0d_rvalid", c), rvalid, 1'b1);
      check_word($sformatf("t4_c%0d_rdata", c), rdata, 32'hDA5A_5B5A);
      check_bit($sformatf("t4_c%0d_arready", c), arready, 1'b0);
    end
    apply_stimulus(1'b1, 32'h8000_0200, 1'b1);
    @(negedge clock);
    check_bit("t4_c7_mem_rready", mem_rready, 1'b1);
    check_bit("t4_c7_arready", arready, 1'b0);
    @(negedge clock);
    check_bit("t4_c8_arready", arready, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check_word("t4_c9_mem_araddr", mem_araddr, 32'h8000_0200);
    @(negedge clock);
    check_bit("t4_c10_rvalid", rvalid, 1'b1);
    check_word("t4_c10_rdata", rdata, 32'hDA5A_585A);
    @(negedge clock);

    // Back-to-back CLINT reads: low word then high word, in order.
    apply_stimulus(1'b1, 32'h0200_BFF8, 1'b1);
    @(negedge clock);
    apply_stimulus(1'b1, 32'h0200_BFFC, 1'b1);
    @(negedge clock);
    check_word("t5_c1_clint_araddr", clint_araddr, 32'h0200_BFF8);
    check_bit("t5_c1_arready", arready, 1'b0);
    @(negedge clock);
    check_word("t5_c2_rdata", rdata, 32'h1234_5678);
    @(negedge clock);
    check_bit("t5_c3_arready", arready, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check_word("t5_c4_clint_araddr", clint_araddr, 32'h0200_BFFC);
    @(negedge clock);
    check_bit("t5_c5_rvalid", rvalid, 1'b1);
    check_word("t5_c5_rdata", rdata, 32'h0000_00AB);
    @(negedge clock);

    // Reset asserted while the memory slave is stalling AR.
    mem_ar_wait = 20;
    apply_stimulus(1'b1, 32'h8000_0040, 1'b1);
    @(negedge clock);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    check_bit("t6_c1_mem_arvalid", mem_arvalid, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_bit("t6_rst_arready", arready, 1'b1);
    check_bit("t6_rst_mem_arvalid", mem_arvalid, 1'b0);
    check_bit("t6_rst_mem_rready", mem_rready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    mem_ar_wait = 0;
    @(negedge clock);
    check_bit("t6_post_arready", arready, 1'b1);
    check_bit("t6_post_mem_arvalid", mem_arvalid, 1'b0);
    apply_stimulus(1'b1, 32'h8000_0004, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clock);

    check_word("resp_count", 32'(n_resp), 32'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
